// File: rtl/conv_1x1_mac_param.sv
// ============================================================================
//  Module      : conv_1x1_mac_param
//  Description : Parametrised serial 1x1 convolution MAC with ready handshake,
//                runtime stride-2 decimation and optional fused ReLU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_1x1_mac_param #(
    parameter int DATA_WIDTH      = 16,
    parameter int FRAC_BITS       = 8,
    parameter int CHANNEL_NUM_IN  = 4,
    parameter int CHANNEL_NUM_OUT = 4,
    parameter int IMAGE_WIDTH     = 8,
    parameter int IMAGE_HEIGHT    = 8,
    parameter int ACC_WIDTH       = 2*DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_weight_in,
    input  logic signed [DATA_WIDTH-1:0] weight_in,
    output logic                         weights_loaded,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] pxl_in,
    output logic                         ready_in,
    input  logic                         stride2,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] pxl_out,
    output logic                         valid_out
);

    localparam int NUM_W = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
    localparam int K_W   = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam int IC_W  = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);

    localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_W - 1);
    localparam logic [IC_W-1:0]  IC_LAST  = IC_W'(CHANNEL_NUM_IN - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD_W  = 2'd0,
        S_FILL    = 2'd1,
        S_COMPUTE = 2'd2
    } state_t;

    state_t                        state_q;
    logic                          weights_loaded_q;
    logic [K_W-1:0]                k_q;
    logic [IC_W-1:0]               ic_q;
    logic [COL_W-1:0]              col_q;
    logic [ROW_W-1:0]              row_q;
    logic                          stride2_lat_q;
    logic                          relu_lat_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [DATA_WIDTH-1:0]  pxl_out_q;
    logic                          valid_out_q;

    logic signed [DATA_WIDTH-1:0]  wmem_q [NUM_W];
    logic signed [DATA_WIDTH-1:0]  pbuf_q [CHANNEL_NUM_IN];

    // k_q indexes weights during load and walks w[oc][ic] flat during compute
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD_W && valid_weight_in)
            wmem_q[k_q] <= weight_in;
        if (state_q == S_FILL && valid_in)
            pbuf_q[ic_q] <= pxl_in;
    end

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [ACC_WIDTH-1:0]    scaled;
    logic signed [DATA_WIDTH-1:0]   sat_val;
    logic signed [DATA_WIDTH-1:0]   out_d;

    assign prod     = pbuf_q[ic_q] * wmem_q[k_q];
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    assign acc_d    = (ic_q == '0) ? prod_ext : acc_q + prod_ext;
    assign scaled   = acc_d >>> FRAC_BITS;

    always_comb begin
        sat_val = scaled[DATA_WIDTH-1:0];
        if (scaled > SAT_MAX)
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (scaled < SAT_MIN)
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    assign out_d = (relu_lat_q && sat_val[DATA_WIDTH-1]) ? '0 : sat_val;

    logic accept;
    logic frame_start;
    logic stride_eff;
    logic keep;

    assign accept      = (state_q == S_FILL) && valid_in;
    assign frame_start = (col_q == '0) && (row_q == '0) && (ic_q == '0);
    // With one input channel the latch and the keep decision share a cycle
    assign stride_eff  = (accept && frame_start) ? stride2 : stride2_lat_q;
    assign keep        = !(stride_eff && (col_q[0] || row_q[0]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_LOAD_W;
            weights_loaded_q <= 1'b0;
            k_q              <= '0;
            ic_q             <= '0;
            col_q            <= '0;
            row_q            <= '0;
            stride2_lat_q    <= 1'b0;
            relu_lat_q       <= 1'b0;
            acc_q            <= '0;
            pxl_out_q        <= '0;
            valid_out_q      <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            case (state_q)
                S_LOAD_W: begin
                    if (valid_weight_in) begin
                        if (k_q == K_LAST) begin
                            k_q              <= '0;
                            state_q          <= S_FILL;
                            weights_loaded_q <= 1'b1;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        if (frame_start) begin
                            stride2_lat_q <= stride2;
                            relu_lat_q    <= relu_en;
                        end
                        if (ic_q == IC_LAST) begin
                            ic_q <= '0;
                            if (col_q == COL_LAST) begin
                                col_q <= '0;
                                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                            if (keep)
                                state_q <= S_COMPUTE;
                        end else begin
                            ic_q <= ic_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc_q <= acc_d;
                    if (ic_q == IC_LAST) begin
                        ic_q        <= '0;
                        pxl_out_q   <= out_d;
                        valid_out_q <= 1'b1;
                    end else begin
                        ic_q <= ic_q + 1'b1;
                    end
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= S_FILL;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: state_q <= S_LOAD_W;
            endcase
        end
    end

    assign weights_loaded = weights_loaded_q;
    assign ready_in       = (state_q == S_FILL);
    assign pxl_out        = pxl_out_q;
    assign valid_out      = valid_out_q;

endmodule

`default_nettype wire

// File: doc/conv_1x1_mac_param.md
Name: conv_1x1_mac_param

Overview:
- Parametrised 1x1 convolution engine: successor to the fixed 304->256 channel 1x1 conv chain.
- Generalised in channel counts, image size and fixed-point format.
- Adds a ready_in backpressure handshake, a runtime stride-2 decimation mode and an optional fused ReLU.
- Sits between a channel-interleaved pixel source and the output alignment stage. For each kept pixel it emits CHANNEL_NUM_OUT results, serially, ordered oc = 0 first.

Parameters:
DATA_WIDTH, 16, signed two's-complement width of pixels, weights and outputs
FRAC_BITS, 8, fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
CHANNEL_NUM_IN, 4, input channels per pixel (>=1)
CHANNEL_NUM_OUT, 4, output channels per pixel (>=1)
IMAGE_WIDTH, 8, pixels per row (>=2)
IMAGE_HEIGHT, 8, rows per frame (>=2)
ACC_WIDTH, 2*DATA_WIDTH+$clog2(CHANNEL_NUM_IN)+1, accumulator width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
valid_weight_in  input  1  weight word strobe
weight_in  input  DATA_WIDTH  weight word, order w[oc][ic], ic fastest
weights_loaded  output  1  high once all CHANNEL_NUM_OUT*CHANNEL_NUM_IN weights are stored
valid_in  input  1  pixel word strobe
pxl_in  input  DATA_WIDTH  pixel channel word, ic = 0 first
ready_in  output  1  high when a pixel word is accepted this cycle
stride2  input  1  1 = keep only even-row/even-col pixels
relu_en  input  1  1 = clamp negative results to 0
pxl_out  output  DATA_WIDTH  result word
valid_out  output  1  pxl_out valid, one cycle per word

Behaviour:
- Reset values (asynchronous):
  - State LOAD_W, weights_loaded=0, ready_in=0, valid_out=0, pxl_out=0.
  - All counters cleared (weight, channel, oc/ic, col, row).
  - Weight store contents are don't-care after reset.
- LOAD_W:
  - Each valid_weight_in stores one word at the running index.
  - On the cycle the last word (index COUT*CIN-1) is stored, the next state is FILL and weights_loaded rises the following cycle.
  - weights_loaded stays high until reset. Weight reload requires reset.
  - valid_weight_in outside LOAD_W is ignored.
- FILL:
  - ready_in=1.
  - A word is accepted when valid_in && ready_in; it is written to pixel buffer slot ic and ic increments.
  - On the CIN-th accepted word, the stride check runs:
    - If the pixel is dropped (stride2_lat=1 and col or row odd), no compute happens, the state stays FILL and ready_in stays 1.
    - Otherwise the next state is COMPUTE.
  - col/row advance per completed pixel. Both wrap to 0 at IMAGE_WIDTH-1 / IMAGE_HEIGHT-1, and the next pixel starts a new frame.
  - valid_in while ready_in=0 (LOAD_W or COMPUTE) is dropped with no state change. Upstream must honour ready_in.
- Frame-start latch:
  - stride2 and relu_en are latched (stride2_lat, relu_lat) when the first word of pixel (0,0) is accepted.
  - They are constant for the rest of the frame.
- COMPUTE:
  - ready_in=0. Runs exactly CIN*COUT cycles, k=0..CIN*COUT-1, with oc=k/CIN and ic=k%CIN.
  - Each cycle forms the signed product buf[ic]*w[oc][ic] (2*DATA_WIDTH) and adds it to acc (ACC_WIDTH, sign-extended).
  - acc is cleared at ic=0: acc <= product.
  - On ic=CIN-1, the sum s = acc+product is post-processed:
    - Scale: r = s >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
    - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - If relu_lat and r<0, r = 0.
    - Register r into pxl_out; valid_out=1 the next cycle for exactly one cycle.
  - Latency: the first word of a kept pixel's compute begins the cycle after the last input word is accepted. Output oc appears at cycle (oc+1)*CIN after COMPUTE entry.
  - After the final cycle the state returns to FILL: ready_in=1 in the same cycle the last valid_out is high.
  - pxl_out holds its last value while valid_out=0.
- Edge case, CIN=1: one cycle per output; valid_out is high every cycle of COMPUTE+1.
- Reset mid-operation (any state): everything returns to the reset values. Any partial pixel or output sequence is discarded with no further valid_out, and weights must be reloaded.

Test Plan:
- Basic MAC: CIN=2, COUT=2, FRAC=8; weights 256,512,-256,128; pixel (256,256), relu_en=0 -> valid_out words 768 then -128; ready_in low exactly 4 cycles.
- ReLU: same as basic MAC with relu_en=1 at frame start -> 768 then 0. Toggling relu_en mid-frame has no effect until the next frame.
- Saturation: DATA_WIDTH=16, CIN=2, all weights and pixels 32767 -> 32767; weights -32768, pixels 32767 -> -32768.
- Stride2: 4x4 frame, CIN=2, COUT=2, stride2=1 -> 16 pixels accepted, outputs only for (0,0),(0,2),(2,0),(2,2) = 8 words. A second frame with stride2=0 -> 32 words.
- Handshake: hold valid_in=1 continuously -> words presented while ready_in=0 are dropped; pixel count matches accepted words only. valid_in before weights_loaded is ignored.
- Reset mid-compute: assert reset at COMPUTE cycle 1 -> valid_out never rises, weights_loaded=0, ready_in=0. After reload, the basic MAC vector reproduces 768 and -128.
